apb_master_bridge: RTL

//  Synthesisable APB3 requester. Converts a valid/ready request stream into APB transfers
//  and fans out to NUM_SLV completers via address-decoded PSEL. Adds PREADY wait states and

---
 rtl/apb_master_bridge_pkg.sv | 23 ++
 rtl/apb_master_bridge_if.sv | 44 ++++
 rtl/apb_master_bridge_addr_decoder.sv | 25 ++
 rtl/apb_master_bridge.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB3 master bridge: default bus geometry,
// FSM state encoding and the select-width helper.
package apb_master_bridge_pkg;

   localparam int APB_ADDR_WIDTH   = 32;
   localparam int APB_DATA_WIDTH   = 32;
   localparam int APB_NUM_SLV      = 4;
   localparam int APB_SLV_ADDR_LSB = 12;
   localparam int APB_TIMEOUT_CYC  = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_mst_state_e;

   // Width of the slave index field; at least one bit even for a single completer.
   function automatic int sel_width(input int num_slv);
      return (num_slv > 1) ? $clog2(num_slv) : 1;
   endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response stream plus APB3 bus bundle for apb_master_bridge.
// master: the bridge side (accepts requests, drives the APB requester signals).
// slave : the environment side (request source, response sink and completers).
interface apb_master_bridge_if
   import apb_master_bridge_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_WIDTH,
   parameter int DATA_W  = APB_DATA_WIDTH,
   parameter int NUM_SLV = APB_NUM_SLV
) ();

   logic                      req_valid;
   logic                      req_ready;
   logic                      req_write;
   logic [ADDR_W-1:0]         req_addr;
   logic [DATA_W-1:0]         req_wdata;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [DATA_W-1:0]         rsp_rdata;
   logic                      rsp_err;
   logic [ADDR_W-1:0]         PADDR;
   logic [DATA_W-1:0]         PWDATA;
   logic                      PWRITE;
   logic [NUM_SLV-1:0]        PSEL;
   logic                      PENABLE;
   logic [NUM_SLV*DATA_W-1:0] PRDATA;
   logic [NUM_SLV-1:0]        PREADY;
   logic [NUM_SLV-1:0]        PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE
   );

endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational completer decode: slave-index field of the address -> index,
// one-hot select and out-of-range flag (index >= NUM_SLV).
module apb_addr_decoder
   import apb_master_bridge_pkg::*;
#(
   parameter int NUM_SLV = APB_NUM_SLV,
   parameter int SEL_W   = sel_width(APB_NUM_SLV)
) (
   input  logic [SEL_W-1:0]   field,
   output logic [SEL_W-1:0]   idx,
   output logic [NUM_SLV-1:0] sel,
   output logic               oor
);

   // Decode the index into a one-hot select; no select bit means out of range.
   always_comb begin
      idx = field;
      sel = {NUM_SLV{1'b0}};
      for (int i = 0; i < NUM_SLV; i++) begin
         sel[i] = (field == SEL_W'(i));
      end
      oor = ~|sel;
   end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester bridge: one request in flight, IDLE/SETUP/ACCESS/RESP FSM,
// PREADY wait states, PSLVERR and address-decode errors reported on rsp_err.
// Optional build macro APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYC cycles.
module apb_master_bridge
   import apb_master_bridge_pkg::*;
#(
   parameter int ADDR_W       = APB_ADDR_WIDTH,
   parameter int DATA_W       = APB_DATA_WIDTH,
   parameter int NUM_SLV      = APB_NUM_SLV,
   parameter int SLV_ADDR_LSB = APB_SLV_ADDR_LSB,
   parameter int TIMEOUT_CYC  = APB_TIMEOUT_CYC
) (
   input logic                  apbClk,
   input logic                  rst,
   apb_master_bridge_if.master  bus
);

   localparam int SEL_W = sel_width(NUM_SLV);

   apb_mst_state_e      state_r,     state_s;
   logic [ADDR_W-1:0]   addr_r,      addr_s;
   logic [DATA_W-1:0]   wdata_r,     wdata_s;
   logic                write_r,     write_s;
   logic [SEL_W-1:0]    idx_r,       idx_s;
   logic [NUM_SLV-1:0]  psel_r,      psel_s;
   logic                penable_r,   penable_s;
   logic                req_ready_r, req_ready_s;
   logic                rsp_valid_r, rsp_valid_s;
   logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
   logic                rsp_err_r,   rsp_err_s;

   logic [SEL_W-1:0]    dec_idx_s;
   logic [NUM_SLV-1:0]  dec_sel_s;
   logic                dec_oor_s;
   logic                sel_ready_s;
   logic                sel_err_s;
   logic [DATA_W-1:0]   sel_rdata_s;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    cnt_r, cnt_s;
`else
   // TIMEOUT_CYC only matters with the timeout built in; this keeps it referenced.
   if (TIMEOUT_CYC < 1) begin : g_timeout_cfg_unused
   end
`endif

   apb_addr_decoder #(
      .NUM_SLV (NUM_SLV),
      .SEL_W   (SEL_W)
   ) u_dec (
      .field (bus.req_addr[SLV_ADDR_LSB +: SEL_W]),
      .idx   (dec_idx_s),
      .sel   (dec_sel_s),
      .oor   (dec_oor_s)
   );

   // Pick PREADY/PSLVERR/PRDATA of the latched completer; all others are ignored.
   always_comb begin
      sel_ready_s = 1'b0;
      sel_err_s   = 1'b0;
      sel_rdata_s = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_SLV; i++) begin
         sel_ready_s = (idx_r == SEL_W'(i)) ? bus.PREADY[i]  : sel_ready_s;
         sel_err_s   = (idx_r == SEL_W'(i)) ? bus.PSLVERR[i] : sel_err_s;
         sel_rdata_s = (idx_r == SEL_W'(i)) ? bus.PRDATA[i*DATA_W +: DATA_W] : sel_rdata_s;
      end
   end

   // Next-state and next-output logic; every register holds unless changed below.
   always_comb begin
      state_s     = state_r;
      addr_s      = addr_r;
      wdata_s     = wdata_r;
      write_s     = write_r;
      idx_s       = idx_r;
      psel_s      = psel_r;
      penable_s   = penable_r;
      req_ready_s = req_ready_r;
      rsp_valid_s = rsp_valid_r;
      rsp_rdata_s = rsp_rdata_r;
      rsp_err_s   = rsp_err_r;
`ifdef APB_TIMEOUT_EN
      cnt_s       = cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (bus.req_valid && req_ready_r) begin
               req_ready_s = 1'b0;
               if (dec_oor_s) begin
                  // Decode error: answer immediately, no APB activity at all.
                  state_s     = RESP;
                  rsp_valid_s = 1'b1;
                  rsp_err_s   = 1'b1;
                  rsp_rdata_s = {DATA_W{1'b0}};
               end else begin
                  state_s = SETUP;
                  addr_s  = bus.req_addr;
                  wdata_s = bus.req_wdata;
                  write_s = bus.req_write;
                  idx_s   = dec_idx_s;
                  psel_s  = dec_sel_s;
               end
            end else begin
               req_ready_s = 1'b1;
            end
         end
         SETUP: begin
            state_s   = ACCESS;
            penable_s = 1'b1;
`ifdef APB_TIMEOUT_EN
            cnt_s     = {CNT_W{1'b0}};
`endif
         end
         ACCESS: begin
            if (sel_ready_s) begin
               state_s     = RESP;
               psel_s      = {NUM_SLV{1'b0}};
               penable_s   = 1'b0;
               rsp_valid_s = 1'b1;
               rsp_err_s   = sel_err_s;
               rsp_rdata_s = write_r ? {DATA_W{1'b0}} : sel_rdata_s;
`ifdef APB_TIMEOUT_EN
            end else if (cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
               // Last allowed ACCESS cycle passed without PREADY: abandon the transfer.
               state_s     = RESP;
               psel_s      = {NUM_SLV{1'b0}};
               penable_s   = 1'b0;
               rsp_valid_s = 1'b1;
               rsp_err_s   = 1'b1;
               rsp_rdata_s = {DATA_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
`else
            end else begin
               state_s = ACCESS;
            end
`endif
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_s     = IDLE;
               rsp_valid_s = 1'b0;
               req_ready_s = 1'b1;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s     = IDLE;
            psel_s      = {NUM_SLV{1'b0}};
            penable_s   = 1'b0;
            rsp_valid_s = 1'b0;
            req_ready_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer without a response.
   always_ff @(posedge apbClk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= {DATA_W{1'b0}};
         write_r     <= 1'b0;
         idx_r       <= {SEL_W{1'b0}};
         psel_r      <= {NUM_SLV{1'b0}};
         penable_r   <= 1'b0;
         req_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {DATA_W{1'b0}};
         rsp_err_r   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         cnt_r       <= {CNT_W{1'b0}};
`endif
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         wdata_r     <= wdata_s;
         write_r     <= write_s;
         idx_r       <= idx_s;
         psel_r      <= psel_s;
         penable_r   <= penable_s;
         req_ready_r <= req_ready_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_rdata_r <= rsp_rdata_s;
         rsp_err_r   <= rsp_err_s;
`ifdef APB_TIMEOUT_EN
         cnt_r       <= cnt_s;
`endif
      end
   end

   assign bus.req_ready = req_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;
   assign bus.PADDR     = addr_r;
   assign bus.PWDATA    = wdata_r;
   assign bus.PWRITE    = write_r;
   assign bus.PSEL      = psel_r;
   assign bus.PENABLE   = penable_r;

endmodule
